// File: rtl/vga_frame_reader.sv
// vga_frame_reader: streams a frame buffer from an Avalon read master into a
// first-word-fall-through pixel FIFO. Reads are issued word by word from the
// sampled base address and wrap to a freshly sampled base after FRAME_WORDS
// words. Each read returns data a fixed number of cycles later.
//
// Optional feature: define VGA_FRAME_READER_UNDERFLOW_EN to build the sticky
// underflow detector. When the macro is undefined, underflow is tied to 0.
//
// Handshakes:
//   Avalon side: a read is accepted in any cycle where master_read=1 and
//   master_waitrequest=0. master_read and master_address stay put while
//   master_waitrequest=1.
//   Pixel side: a word transfers (is popped) in any cycle where
//   pixel_valid=1 and pixel_ready=1. pixel_data and pixel_sof describe the
//   head word whenever pixel_valid=1.
//
// The state register is exposed on state_dbg (0=IDLE, 1=FETCH, 2=DRAIN).
module vga_frame_reader #(
  parameter int FRAME_WORDS = 307200,
  parameter int FIFO_DEPTH  = 64,
  parameter int MAX_LATENCY = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        vga_start,
  input  logic [31:0] frame_buffer_base_address,
  input  logic [7:0]  memory_latency,
  output logic [31:0] master_address,
  output logic        master_read,
  input  logic        master_waitrequest,
  input  logic [31:0] master_readdata,
  output logic [31:0] pixel_data,
  output logic        pixel_sof,
  output logic        pixel_valid,
  input  logic        pixel_ready,
  output logic        underflow,
  output logic [1:0]  state_dbg
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int LW = $clog2(MAX_LATENCY + 1);
  localparam int WW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [31:0]          addr_q;
  logic [WW-1:0]        word_cnt;
  logic [LW-1:0]        lat_q;
  logic [LW-1:0]        lat_clamped;
  logic [CW-1:0]        outstanding;
  logic [CW-1:0]        fifo_count;
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [31:0]          fifo_data [FIFO_DEPTH];
  logic                 fifo_sof  [FIFO_DEPTH];
  logic [MAX_LATENCY-1:0] dl_valid;
  logic [MAX_LATENCY-1:0] dl_sof;
  logic [MAX_LATENCY-1:0] ins_mask;
  logic [CW:0]          occupancy;

  logic enter_fetch;
  logic enter_idle;
  logic accept;
  logic last_word;
  logic capture;
  logic push;
  logic pop;

  assign enter_fetch = (state == IDLE)  && (state_nxt == FETCH);
  assign enter_idle  = (state == DRAIN) && (state_nxt == IDLE);

  // Never request more than the FIFO can hold once everything in flight lands.
  assign occupancy   = {1'b0, fifo_count} + {1'b0, outstanding};
  assign master_read = (state == FETCH) && (occupancy < (CW+1)'(FIFO_DEPTH));
  assign master_address = addr_q;
  assign accept      = master_read && !master_waitrequest;
  assign last_word   = (word_cnt == WW'(FRAME_WORDS - 1));

  // Word that leaves the delay line this cycle lines up with master_readdata.
  assign capture = dl_valid[0];
  assign push    = capture && (state == FETCH);
  assign pop     = pixel_valid && pixel_ready;

  assign pixel_valid = (fifo_count != '0);
  assign pixel_data  = pixel_valid ? fifo_data[rd_ptr] : 32'd0;
  assign pixel_sof   = pixel_valid ? fifo_sof[rd_ptr]  : 1'b0;
  assign state_dbg   = state;

  // Latency 0 behaves as 1; anything past the delay line length saturates.
  always_comb begin
    lat_clamped = LW'(1);
    if (memory_latency == 8'd0) begin
      lat_clamped = LW'(1);
    end else if (32'(memory_latency) > 32'(MAX_LATENCY)) begin
      lat_clamped = LW'(MAX_LATENCY);
    end else begin
      lat_clamped = LW'(memory_latency);
    end
  end

  // Next-state logic for the fetch session.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (vga_start)         state_nxt = FETCH;
      FETCH:   if (!vga_start)        state_nxt = DRAIN;
      DRAIN:   if (outstanding == '0) state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Address, word counter and latency: resampled on session start and frame wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q   <= 32'd0;
      word_cnt <= '0;
      lat_q    <= LW'(1);
    end else if (enter_fetch) begin
      addr_q   <= frame_buffer_base_address;
      word_cnt <= '0;
      lat_q    <= lat_clamped;
    end else if (accept) begin
      if (last_word) begin
        addr_q   <= frame_buffer_base_address;
        word_cnt <= '0;
        lat_q    <= lat_clamped;
      end else begin
        addr_q   <= addr_q + 32'd4;
        word_cnt <= word_cnt + WW'(1);
      end
    end
  end

  // An accepted read is dropped into the slot that reaches bit 0 after lat_q cycles.
  always_comb begin
    ins_mask = '0;
    if (accept) ins_mask = MAX_LATENCY'(1) << (lat_q - LW'(1));
  end

  // Delay line shifting toward bit 0; the latency is constant while reads are in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dl_valid <= '0;
      dl_sof   <= '0;
    end else begin
      dl_valid <= (dl_valid >> 1) | ins_mask;
      dl_sof   <= (dl_sof >> 1) | (ins_mask & {MAX_LATENCY{word_cnt == '0}});
    end
  end

  // Reads in flight: up on acceptance, down on capture, unchanged when both.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outstanding <= '0;
    end else begin
      case ({accept, capture})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // FIFO storage; contents are only meaningful between rd_ptr and wr_ptr.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= master_readdata;
      fifo_sof[wr_ptr]  <= dl_sof[0];
    end
  end

  // FIFO pointers and count; emptied when the session ends.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (enter_idle) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

`ifdef VGA_FRAME_READER_UNDERFLOW_EN
  logic popped_q;
  logic underflow_q;

  // Sticky starvation flag, armed by the first pop of the session.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      popped_q    <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (enter_fetch)                  popped_q <= 1'b0;
      else if ((state == FETCH) && pop) popped_q <= 1'b1;

      if (enter_idle) begin
        underflow_q <= 1'b0;
      end else if ((state == FETCH) && pixel_ready && !pixel_valid && popped_q) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign underflow = underflow_q;
`else
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_vga_frame_reader.sv
// tb_vga_frame_reader: directed bench for vga_frame_reader with a small
// fixed-latency Avalon memory responder and a pixel scoreboard.
module tb_vga_frame_reader;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

`ifdef VGA_FRAME_READER_UNDERFLOW_EN
  localparam logic EXP_UF = 1'b1;
`else
  localparam logic EXP_UF = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        vga_start = 1'b0;
  logic [31:0] base = 32'd0;
  logic [7:0]  memory_latency = 8'd0;
  logic [31:0] master_address;
  logic        master_read;
  logic        master_waitrequest = 1'b0;
  logic [31:0] master_readdata = 32'd0;
  logic [31:0] pixel_data;
  logic        pixel_sof;
  logic        pixel_valid;
  logic        pixel_ready = 1'b0;
  logic        underflow;
  logic [1:0]  state_dbg;

  vga_frame_reader #(
    .FRAME_WORDS(8),
    .FIFO_DEPTH (64),
    .MAX_LATENCY(32)
  ) dut (
    .clk                      (clk),
    .reset_n                  (reset_n),
    .vga_start                (vga_start),
    .frame_buffer_base_address(base),
    .memory_latency           (memory_latency),
    .master_address           (master_address),
    .master_read              (master_read),
    .master_waitrequest       (master_waitrequest),
    .master_readdata          (master_readdata),
    .pixel_data               (pixel_data),
    .pixel_sof                (pixel_sof),
    .pixel_valid              (pixel_valid),
    .pixel_ready              (pixel_ready),
    .underflow                (underflow),
    .state_dbg                (state_dbg)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // memory model state
  int          model_lat = 1;
  int          stall_mode = 0;
  int          acc_count = 0;
  int          first_acc = -1;
  int          stall_viol = 0;
  logic        prev_stalled = 1'b0;
  logic [31:0] prev_addr = 32'd0;
  logic [31:0] acc_addr[$];
  int          rsp_due[$];
  logic [31:0] rsp_data[$];

  // scoreboard
  logic        sb_en = 1'b0;
  int          sb_pops = 0;
  logic [31:0] exp_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_state(input logic [1:0] s, input int limit, input string tag);
    int n = 0;
    while (state_dbg !== s && n < limit) begin
      tick(1);
      n++;
    end
    chk(tag, {30'd0, state_dbg}, {30'd0, s});
  endtask

  task automatic wait_valid(input int limit, input string tag);
    int n = 0;
    while (pixel_valid !== 1'b1 && n < limit) begin
      tick(1);
      n++;
    end
    chk(tag, {31'd0, pixel_valid}, 32'd1);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder, stall generator, acceptance log and pixel scoreboard.
  always @(negedge clk) begin
    logic [31:0] exp_w;
    if (rsp_due.size() > 0 && rsp_due[0] == cyc) begin
      master_readdata = rsp_data.pop_front();
      void'(rsp_due.pop_front());
    end else begin
      master_readdata = 32'hBAD0_BAD0;
    end

    case (stall_mode)
      1:       master_waitrequest = 1'($urandom_range(0, 1));
      2:       master_waitrequest = ((cyc % 4) != 0);
      default: master_waitrequest = 1'b0;
    endcase

    if (prev_stalled && state_dbg == S_FETCH && (!master_read || master_address != prev_addr))
      stall_viol++;
    prev_stalled = master_read && master_waitrequest;
    prev_addr    = master_address;

    if (sb_en && pixel_valid && pixel_ready) begin
      sb_pops++;
      exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
      chk("sb_pixel", pixel_data, exp_w);
    end

    if (master_read && !master_waitrequest) begin
      acc_count++;
      acc_addr.push_back(master_address);
      rsp_due.push_back(cyc + model_lat);
      rsp_data.push_back(mem_word(master_address));
      if (sb_en) exp_q.push_back(mem_word(master_address));
      if (first_acc < 0) first_acc = cyc;
    end
  end

  initial begin
    // reset state
    tick(2);
    chk("rst_read", {31'd0, master_read}, 32'd0);
    chk("rst_addr", master_address, 32'd0);
    chk("rst_valid", {31'd0, pixel_valid}, 32'd0);
    chk("rst_data", pixel_data, 32'd0);
    chk("rst_sof", {31'd0, pixel_sof}, 32'd0);
    chk("rst_uf", {31'd0, underflow}, 32'd0);
    chk("rst_state", {30'd0, state_dbg}, {30'd0, S_IDLE});
    reset_n = 1'b1;
    tick(3);
    chk("idle_no_read", {31'd0, master_read}, 32'd0);

    // basic fetch and frame wrap
    acc_addr.delete();
    base = 32'h1000; memory_latency = 8'd3; model_lat = 3; pixel_ready = 1'b1;
    vga_start = 1'b1;
    chk("start_no_read", {31'd0, master_read}, 32'd0);
    tick(1);
    chk("fetch_state", {30'd0, state_dbg}, {30'd0, S_FETCH});
    chk("first_read", {31'd0, master_read}, 32'd1);
    chk("first_addr", master_address, 32'h1000);
    tick(1);
    chk("second_addr", master_address, 32'h1004);
    chk("no_valid_c2", {31'd0, pixel_valid}, 32'd0);
    base = 32'h2000;
    tick(2);
    chk("no_valid_c4", {31'd0, pixel_valid}, 32'd0);
    tick(1);
    chk("first_valid", {31'd0, pixel_valid}, 32'd1);
    chk("first_sof", {31'd0, pixel_sof}, 32'd1);
    chk("first_data", pixel_data, mem_word(32'h1000));
    tick(1);
    chk("w1_data", pixel_data, mem_word(32'h1004));
    chk("w1_sof", {31'd0, pixel_sof}, 32'd0);
    tick(6);
    chk("w7_data", pixel_data, mem_word(32'h101C));
    chk("w7_sof", {31'd0, pixel_sof}, 32'd0);
    tick(1);
    chk("wrap_data", pixel_data, mem_word(32'h2000));
    chk("wrap_sof", {31'd0, pixel_sof}, 32'd1);
    chk("w7_addr", acc_addr[7], 32'h101C);
    chk("wrap_addr", acc_addr[8], 32'h2000);
    vga_start = 1'b0;
    wait_state(S_IDLE, 100, "p1_idle");
    chk("p1_flushed", {31'd0, pixel_valid}, 32'd0);

    // backpressure
    acc_addr.delete(); acc_count = 0;
    base = 32'h3000; pixel_ready = 1'b0;
    vga_start = 1'b1;
    tick(100);
    chk("bp_count", acc_count, 32'd64);
    chk("bp_read_off", {31'd0, master_read}, 32'd0);
    chk("bp_head_sof", {31'd0, pixel_sof}, 32'd1);
    chk("bp_head", pixel_data, mem_word(32'h3000));
    pixel_ready = 1'b1;
    tick(1);
    pixel_ready = 1'b0;
    chk("bp_pop_head", pixel_data, mem_word(32'h3004));
    tick(10);
    chk("bp_one_more", acc_count, 32'd65);
    chk("bp_read_off2", {31'd0, master_read}, 32'd0);
    chk("bp_extra_addr", acc_addr[64], 32'h3000);
    vga_start = 1'b0;
    wait_state(S_IDLE, 100, "p3_idle");
    chk("p3_flushed", {31'd0, pixel_valid}, 32'd0);

    // random stalls, latency 0 -> 1
    exp_q.delete(); stall_viol = 0; sb_pops = 0; first_acc = -1;
    base = 32'h4000; memory_latency = 8'd0; model_lat = 1; stall_mode = 1;
    sb_en = 1'b1; pixel_ready = 1'b0;
    vga_start = 1'b1;
    wait_valid(100, "lat0_valid");
    chk("lat0_latency", cyc - 1 - first_acc, 32'd1);
    for (int i = 0; i < 300; i++) begin
      pixel_ready = 1'($urandom_range(0, 1));
      tick(1);
    end
    sb_en = 1'b0;
    vga_start = 1'b0;
    wait_state(S_IDLE, 200, "p4_idle");
    exp_q.delete();
    chk("sb_activity", {31'd0, sb_pops > 20}, 32'd1);

    // random stalls, latency 200 -> 32
    first_acc = -1; pixel_ready = 1'b0;
    memory_latency = 8'd200; model_lat = 32;
    vga_start = 1'b1;
    wait_valid(200, "lat200_valid");
    chk("lat200_latency", cyc - 1 - first_acc, 32'd32);
    chk("lat200_data", pixel_data, mem_word(32'h4000));
    vga_start = 1'b0;
    wait_state(S_IDLE, 200, "p4b_idle");
    chk("stall_hold", stall_viol, 32'd0);
    stall_mode = 0;

    // stop with 5 outstanding, restart during DRAIN
    acc_count = 0;
    base = 32'h5000; memory_latency = 8'd10; model_lat = 10; pixel_ready = 1'b1;
    vga_start = 1'b1;
    tick(5);
    vga_start = 1'b0;
    tick(1);
    chk("drain_state", {30'd0, state_dbg}, {30'd0, S_DRAIN});
    chk("drain_no_read", {31'd0, master_read}, 32'd0);
    chk("drain_outstanding", acc_count, 32'd5);
    tick(2);
    vga_start = 1'b1;
    tick(1);
    chk("drain_ignore_start", {30'd0, state_dbg}, {30'd0, S_DRAIN});
    chk("drain_ignore_read", {31'd0, master_read}, 32'd0);
    tick(4);
    chk("drain_discard", {31'd0, pixel_valid}, 32'd0);
    tick(3);
    chk("drain_last", {30'd0, state_dbg}, {30'd0, S_DRAIN});
    tick(1);
    chk("drain_to_idle", {30'd0, state_dbg}, {30'd0, S_IDLE});
    chk("idle_empty", {31'd0, pixel_valid}, 32'd0);
    tick(1);
    chk("restart_state", {30'd0, state_dbg}, {30'd0, S_FETCH});
    chk("restart_read", {31'd0, master_read}, 32'd1);
    chk("restart_addr", master_address, 32'h5000);
    tick(11);
    chk("restart_valid", {31'd0, pixel_valid}, 32'd1);
    chk("restart_sof", {31'd0, pixel_sof}, 32'd1);
    chk("restart_data", pixel_data, mem_word(32'h5000));
    vga_start = 1'b0;
    wait_state(S_IDLE, 100, "p5_idle");

    // underflow: supply at one word per four cycles, consumer always ready
    base = 32'h6000; memory_latency = 8'd2; model_lat = 2;
    stall_mode = 2; pixel_ready = 1'b1;
    vga_start = 1'b1;
    tick(100);
    chk("uf_set", {31'd0, underflow}, {31'd0, EXP_UF});
    pixel_ready = 1'b0; stall_mode = 0;
    tick(20);
    chk("uf_sticky", {31'd0, underflow}, {31'd0, EXP_UF});
    vga_start = 1'b0;
    wait_state(S_IDLE, 100, "p6_idle");
    chk("uf_clear_idle", {31'd0, underflow}, 32'd0);

    // asynchronous reset with traffic in flight
    vga_start = 1'b1;
    tick(6);
    chk("pre_rst_valid", {31'd0, pixel_valid}, 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_read", {31'd0, master_read}, 32'd0);
    chk("arst_addr", master_address, 32'd0);
    chk("arst_valid", {31'd0, pixel_valid}, 32'd0);
    chk("arst_data", pixel_data, 32'd0);
    chk("arst_sof", {31'd0, pixel_sof}, 32'd0);
    chk("arst_state", {30'd0, state_dbg}, {30'd0, S_IDLE});
    vga_start = 1'b0;
    tick(1);
    reset_n = 1'b1;
    tick(2);
    chk("post_rst_no_read", {31'd0, master_read}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
